// File: rtl/result_checker_pkg.sv
// Shared widths, state encoding and helpers for the result checker slice.
// CHK_MASK_EN widens the expected word to {mask, expected}.
package result_checker_pkg;

   localparam int unsigned RC_RTF_WIDTH = 24;
   localparam int unsigned RC_CNT_WIDTH = 16;

   function automatic int unsigned rc_exp_width(input int unsigned rtf_width);
`ifdef CHK_MASK_EN
      return 2 * rtf_width;
`else
      return rtf_width;
`endif
   endfunction

   localparam int unsigned RC_EXP_WIDTH = rc_exp_width(RC_RTF_WIDTH);
   localparam int unsigned RC_LOG_WIDTH = RC_CNT_WIDTH + 2 * RC_RTF_WIDTH;

   typedef enum logic [1:0] {
      RC_IDLE  = 2'd0,
      RC_RUN   = 2'd1,
      RC_DRAIN = 2'd2,
      RC_DONE  = 2'd3
   } rc_state_t;

endpackage

// File: rtl/result_checker_if.sv
// FIFO-side signal bundle of the result checker: result/expected pop ports and log push port.
interface result_checker_if
   import result_checker_pkg::*;
#(
   parameter int unsigned RTF_WIDTH = RC_RTF_WIDTH,
   parameter int unsigned EXP_WIDTH = RC_EXP_WIDTH,
   parameter int unsigned LOG_WIDTH = RC_LOG_WIDTH
);
   logic [RTF_WIDTH-1:0] rfifo_data;
   logic                 rfifo_rdreq;
   logic                 rfifo_rdempty;
   logic [EXP_WIDTH-1:0] efifo_data;
   logic                 efifo_rdreq;
   logic                 efifo_rdempty;
   logic [LOG_WIDTH-1:0] lfifo_data;
   logic                 lfifo_wrreq;
   logic                 lfifo_wrfull;

   modport master (
      input  rfifo_data, rfifo_rdempty, efifo_data, efifo_rdempty, lfifo_wrfull,
      output rfifo_rdreq, efifo_rdreq, lfifo_data, lfifo_wrreq
   );

   modport slave (
      output rfifo_data, rfifo_rdempty, efifo_data, efifo_rdempty, lfifo_wrfull,
      input  rfifo_rdreq, efifo_rdreq, lfifo_data, lfifo_wrreq
   );
endinterface

// File: rtl/result_checker_compare.sv
// Combinational masked compare of a result word against an expected FIFO word.
// CHK_MASK_EN: exp_word = {mask, expected}, mask bit 1 = care; otherwise exact compare.
module result_compare
   import result_checker_pkg::*;
#(
   parameter int unsigned RTF_WIDTH = RC_RTF_WIDTH,
   parameter int unsigned EXP_WIDTH = RC_EXP_WIDTH
) (
   input  logic [RTF_WIDTH-1:0] result,
   input  logic [EXP_WIDTH-1:0] exp_word,
   output logic [RTF_WIDTH-1:0] expected,
   output logic                 mismatch
);
   logic [RTF_WIDTH-1:0] care;

   always_comb begin
      expected = exp_word[RTF_WIDTH-1:0];
`ifdef CHK_MASK_EN
      care     = exp_word[EXP_WIDTH-1 -: RTF_WIDTH];
`else
      care     = '1;
`endif
      mismatch = |((result ^ expected) & care);
   end
endmodule

// File: rtl/result_checker.sv
// Result checker: pops result/expected FIFOs in lockstep, counts failures, logs mismatches.
// Build option CHK_MASK_EN enables per-bit don't-care masks carried in the expected FIFO.
module result_checker
   import result_checker_pkg::*;
#(
   parameter int unsigned RTF_WIDTH = RC_RTF_WIDTH,
   parameter int unsigned CNT_WIDTH = RC_CNT_WIDTH
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [CNT_WIDTH-1:0] num_vectors,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [CNT_WIDTH-1:0] fail_count,
   result_checker_if.master     fifo
);
   localparam int unsigned EXP_WIDTH = rc_exp_width(RTF_WIDTH);

   rc_state_t            state, state_nxt;
   logic [CNT_WIDTH-1:0] n_vec;
   logic [CNT_WIDTH-1:0] issued;
   logic [CNT_WIDTH-1:0] vec_idx;
   logic                 rd_d1;
   logic                 rd_req;
   logic                 accept;
   logic                 log_push;
   logic                 mismatch;
   logic [RTF_WIDTH-1:0] expected;

   result_compare #(
      .RTF_WIDTH (RTF_WIDTH),
      .EXP_WIDTH (EXP_WIDTH)
   ) u_compare (
      .result   (fifo.rfifo_data),
      .exp_word (fifo.efifo_data),
      .expected (expected),
      .mismatch (mismatch)
   );

   // A mismatch holds off the next pop one cycle so lfifo_wrfull reflects the log write.
   always_comb begin
      accept   = start & ((state == RC_IDLE) | (state == RC_DONE));
      log_push = rd_d1 & mismatch;
      rd_req   = (state == RC_RUN) & ~fifo.rfifo_rdempty & ~fifo.efifo_rdempty
               & ~fifo.lfifo_wrfull & (issued < n_vec) & ~log_push;
      busy     = (state == RC_RUN) | (state == RC_DRAIN);

      fifo.rfifo_rdreq = rd_req;
      fifo.efifo_rdreq = rd_req;
      fifo.lfifo_wrreq = log_push;
      fifo.lfifo_data  = log_push ? {vec_idx, fifo.rfifo_data, expected} : '0;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         RC_IDLE, RC_DONE: if (start) state_nxt = (num_vectors == '0) ? RC_DONE : RC_RUN;
         RC_RUN:           if (issued == n_vec) state_nxt = RC_DRAIN;
         RC_DRAIN:         if (!rd_d1) state_nxt = RC_DONE;
         default:          state_nxt = RC_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= RC_IDLE;
         n_vec      <= '0;
         issued     <= '0;
         vec_idx    <= '0;
         rd_d1      <= 1'b0;
         fail_count <= '0;
         done       <= 1'b0;
         pass       <= 1'b0;
      end else begin
         state <= state_nxt;
         rd_d1 <= rd_req;
         if (accept) begin
            n_vec      <= num_vectors;
            issued     <= '0;
            vec_idx    <= '0;
            fail_count <= '0;
            done       <= (num_vectors == '0);
            pass       <= (num_vectors == '0);
         end else begin
            if (rd_req) issued <= issued + CNT_WIDTH'(1);
            if (rd_d1) vec_idx <= vec_idx + CNT_WIDTH'(1);
            if (log_push && (fail_count != '1)) fail_count <= fail_count + CNT_WIDTH'(1);
            if ((state == RC_DRAIN) && !rd_d1) begin
               done <= 1'b1;
               pass <= (fail_count == '0);
            end
         end
      end
   end
endmodule

// File: tb/tb_result_checker.sv
// Directed bench for result_checker with behavioural normal-mode FIFOs around the DUT.
// Build with CHK_MASK_EN defined to exercise the masked-compare variant.
module tb_result_checker;
   import result_checker_pkg::*;

   localparam int unsigned RW = RC_RTF_WIDTH;
   localparam int unsigned CW = RC_CNT_WIDTH;
   localparam int unsigned EW = RC_EXP_WIDTH;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [CW-1:0] num_vectors = '0;
   logic          busy, done, pass;
   logic [CW-1:0] fail_count;
   logic          wrfull = 1'b0;

   int checks = 0;
   int errors = 0;

   result_checker_if ifc ();

   result_checker #(
      .RTF_WIDTH (RW),
      .CNT_WIDTH (CW)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .num_vectors (num_vectors),
      .busy        (busy),
      .done        (done),
      .pass        (pass),
      .fail_count  (fail_count),
      .fifo        (ifc)
   );

   always #5 clock = ~clock;

   // FIFO model: write pointers owned by the stimulus, read side owned by the clocked process
   logic [RW-1:0] rmem [0:255];
   logic [EW-1:0] emem [0:255];
   logic [63:0]   lmem [0:255];
   logic [RW-1:0] rdata = '0;
   logic [EW-1:0] edata = '0;
   logic          rd_hist [0:4095];
   int r_wr = 0, e_wr = 0, rd_ptr = 0, l_cnt = 0, cyc = 0, split = 0;

   assign ifc.rfifo_data    = rdata;
   assign ifc.efifo_data    = edata;
   assign ifc.rfifo_rdempty = (r_wr == rd_ptr);
   assign ifc.efifo_rdempty = (e_wr == rd_ptr);
   assign ifc.lfifo_wrfull  = wrfull;

   always @(posedge clock) begin
      rd_hist[cyc] <= ifc.rfifo_rdreq;
      cyc <= cyc + 1;
      if (ifc.rfifo_rdreq !== ifc.efifo_rdreq) split <= split + 1;
      if (ifc.rfifo_rdreq) begin
         rdata  <= rmem[rd_ptr];
         edata  <= emem[rd_ptr];
         rd_ptr <= rd_ptr + 1;
      end
      if (ifc.lfifo_wrreq) begin
         lmem[l_cnt] <= ifc.lfifo_data;
         l_cnt <= l_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_res(input logic [RW-1:0] r);
      rmem[r_wr[7:0]] = r;
      r_wr = r_wr + 1;
   endtask

   task automatic push_exp(input logic [RW-1:0] e, input logic [RW-1:0] mask);
`ifdef CHK_MASK_EN
      emem[e_wr[7:0]] = {mask, e};
`else
      emem[e_wr[7:0]] = e;
      if (mask != '1) $display("note: mask ignored in exact-compare build");
`endif
      e_wr = e_wr + 1;
   endtask

   task automatic push_pair(input logic [RW-1:0] r, input logic [RW-1:0] e);
      push_res(r);
      push_exp(e, '1);
   endtask

   task automatic kick(input int n);
      @(negedge clock);
      start = 1'b1;
      num_vectors = CW'(n);
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_done(input int maxc);
      for (int i = 0; i < maxc && !done; i++) @(negedge clock);
      check("done_timeout", done, 1);
   endtask

   // pops and first-to-last pop span over posedges since cycle c0
   task automatic window(input int c0, output int n, output int span);
      int first, last;
      n = 0; first = -1; last = -1;
      for (int i = c0; i < cyc; i++) begin
         if (rd_hist[i]) begin
            n++;
            if (first < 0) first = i;
            last = i;
         end
      end
      span = (first < 0) ? 0 : last - first + 1;
   endtask

   initial begin
      int c0, l0, n, span;

      // reset state
      repeat (2) @(negedge clock);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_fail", fail_count, 0);
      check("rst_rdreq", ifc.rfifo_rdreq, 0);
      check("rst_wrreq", ifc.lfifo_wrreq, 0);
      check("rst_ldata", ifc.lfifo_data, 0);
      reset_n = 1'b1;

      // 1: four matching vectors, back-to-back pops
      c0 = cyc; l0 = l_cnt;
      for (int i = 1; i <= 4; i++) push_pair(RW'(i), RW'(i));
      kick(4);
      check("t1_busy", busy, 1);
      wait_done(40);
      window(c0, n, span);
      check("t1_pops", n, 4);
      check("t1_span", span, 4);
      check("t1_pass", pass, 1);
      check("t1_fail", fail_count, 0);
      check("t1_logs", l_cnt - l0, 0);
      check("t1_busy_end", busy, 0);

      // 2: vector 2 mismatches, one log entry and one bubble
      c0 = cyc; l0 = l_cnt;
      push_pair(24'h000010, 24'h000010);
      push_pair(24'h000020, 24'h000020);
      push_pair(24'h0000FF, 24'h0000F0);
      push_pair(24'h000030, 24'h000030);
      kick(4);
      wait_done(40);
      window(c0, n, span);
      check("t2_pops", n, 4);
      check("t2_span", span, 5);
      check("t2_logs", l_cnt - l0, 1);
      check("t2_entry", lmem[l0], {16'd2, 24'h0000FF, 24'h0000F0});
      check("t2_fail", fail_count, 1);
      check("t2_pass", pass, 0);

      // 3: log FIFO full stalls all pops; release loses nothing
      c0 = cyc; l0 = l_cnt;
      wrfull = 1'b1;
      push_pair(24'h000005, 24'h000005);
      push_pair(24'h000006, 24'h000007);
      kick(2);
      repeat (6) @(negedge clock);
      window(c0, n, span);
      check("t3_stall", n, 0);
      wrfull = 1'b0;
      wait_done(40);
      window(c0, n, span);
      check("t3_pops", n, 2);
      check("t3_logs", l_cnt - l0, 1);
      check("t3_entry", lmem[l0], {16'd1, 24'h000006, 24'h000007});
      check("t3_fail", fail_count, 1);

      // 4: expected FIFO empty blocks both pops
      c0 = cyc;
      push_res(24'h000008);
      push_res(24'h000009);
      kick(2);
      repeat (5) @(negedge clock);
      window(c0, n, span);
      check("t4_stall", n, 0);
      push_exp(24'h000008, '1);
      push_exp(24'h000009, '1);
      wait_done(40);
      window(c0, n, span);
      check("t4_pops", n, 2);
      check("t4_pass", pass, 1);

      // 5: zero-length run, then start ignored while running
      c0 = cyc;
      kick(0);
      check("t5_done0", done, 1);
      check("t5_pass0", pass, 1);
      check("t5_busy0", busy, 0);
      kick(3);
      kick(0);
      check("t5_ign_busy", busy, 1);
      check("t5_ign_done", done, 0);
      for (int i = 0; i < 3; i++) push_pair(RW'(24'h00A0 + i), RW'(24'h00A0 + i));
      wait_done(40);
      window(c0, n, span);
      check("t5_pops", n, 3);
      check("t5_pass", pass, 1);

      // 6: masked compare (or exact LSB compare in the default build)
`ifdef CHK_MASK_EN
      push_res(24'h1234AB);
      push_exp(24'h123400, 24'hFFFF00);
      kick(1);
      wait_done(40);
      check("t6_mask_pass", pass, 1);
      check("t6_mask_fail", fail_count, 0);
`else
      l0 = l_cnt;
      push_pair(24'h000001, 24'h000000);
      kick(1);
      wait_done(40);
      check("t6_exact_pass", pass, 0);
      check("t6_exact_entry", lmem[l0], {16'd0, 24'h000001, 24'h000000});
`endif

      // reset mid-run aborts
      push_pair(24'h000077, 24'h000070);
      for (int i = 0; i < 7; i++) push_pair(RW'(24'h0100 + i), RW'(24'h0100 + i));
      kick(8);
      repeat (2) @(negedge clock);
      check("mr_fail_pre", fail_count, 1);
      reset_n = 1'b0;
      #1;
      check("mr_busy", busy, 0);
      check("mr_done", done, 0);
      check("mr_pass", pass, 0);
      check("mr_fail", fail_count, 0);
      check("mr_rdreq", ifc.rfifo_rdreq, 0);
      check("mr_wrreq", ifc.lfifo_wrreq, 0);
      check("mr_ldata", ifc.lfifo_data, 0);
      @(negedge clock);
      reset_n = 1'b1;
      r_wr = rd_ptr;
      e_wr = rd_ptr;
      kick(0);
      check("mr_restart_done", done, 1);
      check("pop_split", split, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
